// File: rtl/itype_exec_arbiter_pkg.sv
// Shared constants, types and helpers for the OP-IMM execution arbiter.
package itype_arb_pkg;

    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] SRA_FUNCT7 = 7'h20;

    localparam logic [2:0] F3_ADDI  = 3'd0;
    localparam logic [2:0] F3_SLLI  = 3'd1;
    localparam logic [2:0] F3_SLTI  = 3'd2;
    localparam logic [2:0] F3_SLTIU = 3'd3;
    localparam logic [2:0] F3_XORI  = 3'd4;
    localparam logic [2:0] F3_SRLI  = 3'd5;
    localparam logic [2:0] F3_ORI   = 3'd6;
    localparam logic [2:0] F3_ANDI  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [11:0] imm;
        logic [31:0] in1;
    } itype_req_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shift encodings carry funct7 in imm[11:5]; anything not architected is illegal.
    function automatic logic illegal_shift(input logic [2:0] funct3, input logic [11:0] imm);
        logic [6:0] f7;
        f7 = imm[11:5];
        if (funct3 == F3_SLLI)
            return (f7 != 7'h00);
        if (funct3 == F3_SRLI)
            return (f7 != 7'h00) && (f7 != SRA_FUNCT7);
        return 1'b0;
    endfunction

endpackage

// File: rtl/itype_exec_arbiter_if.sv
// Request/response bundle between NREQ requesters and the OP-IMM execution arbiter.
interface itype_exec_arbiter_if
    import itype_arb_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int ID_W = id_width(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][2:0]   req_funct3;
    logic [NREQ-1:0][11:0]  req_imm;
    logic [NREQ-1:0][31:0]  req_in1;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   rsp_err;

    modport master (
        output req_valid, req_funct3, req_imm, req_in1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_funct3, req_imm, req_in1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

endinterface

// File: rtl/itype_exec_arbiter_alu.sv
// Combinational I-type ALU for OP-IMM; logical ops use a zero-extended immediate.
module i_type
    import itype_arb_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [11:0] imm,
    input  logic [31:0] in1,
    output logic [31:0] out
);

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [4:0]  shamt;

    always_comb begin
        imm_sext = {{20{imm[11]}}, imm};
        imm_zext = {20'h0, imm};
        shamt    = imm[4:0];
        out      = '0;
        if (opcode == OP_IMM) begin
            case (funct3)
                F3_ADDI:  out = in1 + imm_sext;
                F3_SLLI:  out = in1 << shamt;
                F3_SLTI:  out = {31'h0, ($signed(in1) < $signed(imm_sext))};
                F3_SLTIU: out = {31'h0, (in1 < imm_sext)};
                F3_XORI:  out = in1 ^ imm_zext;
                F3_SRLI:  out = (imm[11:5] == SRA_FUNCT7) ? 32'($signed(in1) >>> shamt)
                                                          : (in1 >> shamt);
                F3_ORI:   out = in1 | imm_zext;
                F3_ANDI:  out = in1 & imm_zext;
                default:  out = '0;
            endcase
        end
    end

endmodule

// File: rtl/itype_exec_arbiter.sv
// Round-robin arbiter sharing one OP-IMM ALU between NREQ requesters.
// Define ITYPE_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module itype_exec_arbiter
    import itype_arb_pkg::*;
#(
    parameter int NREQ = 2
`ifdef ITYPE_ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic clk,
    input  logic rst,
    itype_exec_arbiter_if.slave bus
`ifdef ITYPE_ARB_STATS_EN
    , output logic [NREQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

    localparam int ID_W = id_width(NREQ);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            found;
    logic [NREQ-1:0] req_ready;
    itype_req_t      lat_req;
    logic [ID_W-1:0] lat_id;
    logic [6:0]      alu_opcode;
    logic [31:0]     alu_out;
    logic            lat_illegal;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic            rsp_err;

    // Reverse scan so the requester closest to ptr wins; returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (valid[idx])
                res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        {found, grant} = rr_pick(bus.req_valid, rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        alu_opcode = 7'b0000000;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[grant] = 1'b1;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                alu_opcode = OP_IMM;
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    i_type u_alu (
        .opcode (alu_opcode),
        .funct3 (lat_req.funct3),
        .imm    (lat_req.imm),
        .in1    (lat_req.in1),
        .out    (alu_out)
    );

    assign lat_illegal = illegal_shift(lat_req.funct3, lat_req.imm);

    // Operand latch on grant, result capture in EXEC, response hold until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            lat_req   <= '0;
            lat_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        lat_req.funct3 <= bus.req_funct3[grant];
                        lat_req.imm    <= bus.req_imm[grant];
                        lat_req.in1    <= bus.req_in1[grant];
                        lat_id         <= grant;
                        rr_ptr         <= ID_W'((int'(grant) + 1) % NREQ);
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= lat_illegal;
                    rsp_data  <= lat_illegal ? 32'h0 : alu_out;
                    rsp_id    <= lat_id;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_err   = rsp_err;

`ifdef ITYPE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            grant_cnt <= '0;
        else if (state == IDLE && found && grant_cnt[grant] != '1)
            grant_cnt[grant] <= grant_cnt[grant] + 1'b1;
    end
`endif

endmodule

// File: tb/tb_itype_exec_arbiter.sv
// Scoreboard bench for itype_exec_arbiter: a reference model queues expected responses at grant time.
module tb_itype_exec_arbiter;
    import itype_arb_pkg::*;

    localparam int NREQ = 2;

    typedef struct {
        logic [31:0] data;
        int          id;
        logic        err;
        int          accept_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    itype_exec_arbiter_if #(.NREQ(NREQ)) bus();

`ifdef ITYPE_ARB_STATS_EN
    logic [NREQ-1:0][15:0] grant_cnt;
`endif

    itype_exec_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ITYPE_ARB_STATS_EN
        , .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          stall_left = 0;
    itype_req_t  pend [NREQ][$];
    exp_t        exp_q[$];
    int          grant_log[$];
    logic [31:0] data_log[$];
    int          id_log[$];
    logic        err_log[$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data;
    int          prev_id;
    logic        prev_err;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Independent OP-IMM reference; logical ops zero-extend the immediate like the shared ALU.
    function automatic exp_t model(input itype_req_t op, input int id);
        exp_t        e;
        logic [31:0] se;
        logic [31:0] ze;
        logic [4:0]  sh;
        logic [6:0]  f7;
        se = {{20{op.imm[11]}}, op.imm};
        ze = {20'h0, op.imm};
        sh = op.imm[4:0];
        f7 = op.imm[11:5];
        e.id = id;
        e.err = 1'b0;
        e.data = 32'h0;
        e.accept_cyc = 0;
        case (op.funct3)
            3'd0: e.data = op.in1 + se;
            3'd1: if (f7 != 7'h00) e.err = 1'b1; else e.data = op.in1 << sh;
            3'd2: e.data = ($signed(op.in1) < $signed(se)) ? 32'd1 : 32'd0;
            3'd3: e.data = (op.in1 < se) ? 32'd1 : 32'd0;
            3'd4: e.data = op.in1 ^ ze;
            3'd5: begin
                if (f7 == 7'h00)      e.data = op.in1 >> sh;
                else if (f7 == 7'h20) e.data = 32'($signed(op.in1) >>> sh);
                else                  e.err = 1'b1;
            end
            3'd6: e.data = op.in1 | ze;
            default: e.data = op.in1 & ze;
        endcase
        return e;
    endfunction

    task automatic pushOp(input int id, input logic [2:0] f3, input logic [11:0] imm, input logic [31:0] in1);
        itype_req_t op;
        op.funct3 = f3;
        op.imm    = imm;
        op.in1    = in1;
        pend[id].push_back(op);
    endtask

    // One step per negedge: drive requests/rsp_ready, then #1 later score grants and responses.
    task automatic applyStimulus(input int max_cycles);
        int         n;
        bit         busy;
        exp_t       e;
        itype_req_t head;
        n = 0;
        forever begin
            @(negedge clk);
            cycle++;
            busy = (exp_q.size() != 0) || (bus.rsp_valid === 1'b1);
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i].size() != 0) begin
                    head = pend[i][0];
                    bus.req_valid[i]  = 1'b1;
                    bus.req_funct3[i] = head.funct3;
                    bus.req_imm[i]    = head.imm;
                    bus.req_in1[i]    = head.in1;
                    busy = 1'b1;
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            if (bus.rsp_valid && stall_left > 0) begin
                bus.rsp_ready = 1'b0;
                stall_left--;
            end else begin
                bus.rsp_ready = 1'b1;
            end
            if (!busy) break;
            if (n >= max_cycles) begin
                checkOutput("drain_timeout", 64'd1, 64'd0);
                for (int i = 0; i < NREQ; i++) pend[i].delete();
                exp_q.delete();
                bus.req_valid = '0;
                break;
            end
            n++;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    head = pend[i][0];
                    e = model(head, i);
                    e.accept_cyc = cycle;
                    exp_q.push_back(e);
                    grant_log.push_back(i);
                    void'(pend[i].pop_front());
                end
            end
            if (bus.rsp_valid) begin
                checkOutput("ready_low_busy", 64'(bus.req_ready), 64'd0);
                if (hold_prev) begin
                    checkOutput("hold_data", 64'(bus.rsp_data), 64'(prev_data));
                    checkOutput("hold_id", 64'(bus.rsp_id), 64'(prev_id));
                    checkOutput("hold_err", 64'(bus.rsp_err), 64'(prev_err));
                end else if (exp_q.size() != 0) begin
                    checkOutput("latency", 64'(cycle - exp_q[0].accept_cyc), 64'd2);
                end
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                        checkOutput("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                        checkOutput("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    end
                    data_log.push_back(bus.rsp_data);
                    id_log.push_back(int'(bus.rsp_id));
                    err_log.push_back(bus.rsp_err);
                end
            end
            hold_prev = bus.rsp_valid && !bus.rsp_ready;
            prev_data = bus.rsp_data;
            prev_id   = int'(bus.rsp_id);
            prev_err  = bus.rsp_err;
        end
    endtask

    function automatic logic [31:0] dataAt(input int back);
        if (data_log.size() < back) return 32'hDEADBEEF;
        return data_log[data_log.size() - back];
    endfunction

    initial begin
        int gl_start;
        bus.req_valid  = '0;
        bus.req_funct3 = '0;
        bus.req_imm    = '0;
        bus.req_in1    = '0;
        bus.rsp_ready  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("idle_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("idle_state", 64'(dut.state), 64'(IDLE));

        $display("[TB] addi on requester 0");
        pushOp(0, 3'd0, 12'h005, 32'h10);
        applyStimulus(40);
        checkOutput("t2_data", 64'(dataAt(1)), 64'h15);
        checkOutput("t2_err", 64'(err_log.size() > 0 ? err_log[err_log.size()-1] : 1'bx), 64'd0);

        $display("[TB] illegal srxi encoding on requester 1");
        pushOp(1, 3'd5, 12'h604, 32'h1234);
        applyStimulus(40);
        checkOutput("t5_data", 64'(dataAt(1)), 64'h0);
        checkOutput("t5_err", 64'(err_log.size() > 0 ? err_log[err_log.size()-1] : 1'bx), 64'd1);

        $display("[TB] both requesters continuously valid");
        for (int k = 0; k < 2; k++) begin
            pushOp(0, 3'd4, 12'hFFF, 32'h0);
            pushOp(1, 3'd6, 12'h001, 32'h2);
        end
        gl_start = grant_log.size();
        applyStimulus(80);
        for (int k = 0; k < 4; k++)
            checkOutput("t3_grant_order",
                        64'((grant_log.size() > gl_start + k) ? grant_log[gl_start + k] : -1),
                        64'(k % 2));
        checkOutput("t3_xori", 64'(dataAt(4)), 64'h00000FFF);
        checkOutput("t3_ori", 64'(dataAt(3)), 64'h3);

        $display("[TB] srai with consumer stalled");
        stall_left = 5;
        pushOp(0, 3'd5, 12'h404, 32'h80000000);
        pushOp(1, 3'd0, 12'h7FF, 32'h1);
        applyStimulus(80);
        checkOutput("t4_stall_used", 64'(stall_left), 64'd0);
        checkOutput("t4_srai", 64'(dataAt(2)), 64'hF8000000);

        $display("[TB] mixed OP-IMM patterns");
        pushOp(0, 3'd2, 12'hFFF, 32'hFFFFFFFE);
        pushOp(1, 3'd3, 12'hFFF, 32'h5);
        pushOp(0, 3'd7, 12'hF0F, 32'hFFFFFFFF);
        pushOp(1, 3'd1, 12'h01F, 32'h1);
        pushOp(0, 3'd5, 12'h008, 32'h80000000);
        pushOp(1, 3'd1, 12'h020, 32'h1);
        pushOp(0, 3'd0, 12'h800, 32'h0);
        stall_left = 2;
        applyStimulus(120);

        $display("[TB] reset while executing");
        @(negedge clk);
        bus.req_valid  = 2'b01;
        bus.req_funct3[0] = 3'd0;
        bus.req_imm[0]    = 12'h001;
        bus.req_in1[0]    = 32'h1;
        #1;
        checkOutput("t6_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = '0;
        checkOutput("t6_in_exec", 64'(dut.state), 64'(EXEC));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("t6_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        rst = 1'b0;
        hold_prev = 1'b0;
        pushOp(0, 3'd0, 12'h002, 32'h3);
        pushOp(1, 3'd0, 12'h003, 32'h4);
        gl_start = grant_log.size();
        applyStimulus(60);
        checkOutput("t6_rr_first",
                    64'((grant_log.size() > gl_start) ? grant_log[gl_start] : -1), 64'd0);
        pushOp(1, 3'd6, 12'h010, 32'h1);
        pushOp(1, 3'd4, 12'h00F, 32'hF0);
        applyStimulus(60);
`ifdef ITYPE_ARB_STATS_EN
        checkOutput("cnt_req1", 64'(grant_cnt[1]), 64'd3);
        checkOutput("cnt_req0", 64'(grant_cnt[0]), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
